// File: rtl/lane_deskew_aggregator.sv
// ---------------------------------------------------------------------------
// lane_deskew_aggregator
//
// Receive-path lane aggregator. Each physical lane feeds its own elastic FIFO
// so lanes may arrive skewed by several beats. Once every enabled lane holds
// at least one beat, one beat is popped from every enabled FIFO and
// registered as a single full-width output beat (valid/ready handshake).
// A skew watchdog flushes all FIFOs if lanes stay partially filled for
// SKEW_LIMIT cycles. Any change of the lane-enable mask also flushes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   lane_enable       per-lane participation mask
//   lane_valid/ready  per-lane push handshake
//   lane_data         lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//   out_valid/ready   aggregated beat handshake
//   out_data          aggregated beat, disabled lane slices are zero
//   out_lane_mask     enable mask in force when the beat was formed
//   skew_err          sticky skew error, cleared by clear_err
//   flush_count       number of skew flushes, saturating at 255
// ---------------------------------------------------------------------------
module lane_deskew_aggregator #(
  parameter int NUM_LANES  = 4,
  parameter int LANE_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int SKEW_LIMIT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            lane_enable,
  input  logic [NUM_LANES-1:0]            lane_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_data,
  output logic [NUM_LANES-1:0]            lane_ready,
  output logic                            out_valid,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            out_lane_mask,
  input  logic                            out_ready,
  output logic                            skew_err,
  input  logic                            clear_err,
  output logic [7:0]                      flush_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(SKEW_LIMIT + 1);
  localparam logic [CW-1:0] SKEW_LAST = CW'(SKEW_LIMIT - 1);

  logic [LANE_WIDTH-1:0]           mem_q [NUM_LANES][FIFO_DEPTH];
  logic [LANE_WIDTH-1:0]           mem_d [NUM_LANES][FIFO_DEPTH];
  logic [PW-1:0]                   wr_ptr_q [NUM_LANES];
  logic [PW-1:0]                   wr_ptr_d [NUM_LANES];
  logic [PW-1:0]                   rd_ptr_q [NUM_LANES];
  logic [PW-1:0]                   rd_ptr_d [NUM_LANES];
  logic [CW-1:0]                   skew_cnt_q, skew_cnt_d;
  logic                            out_valid_q, out_valid_d;
  logic [NUM_LANES*LANE_WIDTH-1:0] out_data_q, out_data_d;
  logic [NUM_LANES-1:0]            out_lane_mask_q, out_lane_mask_d;
  logic                            skew_err_q, skew_err_d;
  logic [7:0]                      flush_count_q, flush_count_d;
  logic [NUM_LANES-1:0]            lane_enable_q, lane_enable_d;

  logic [NUM_LANES-1:0] fifo_empty;
  logic [NUM_LANES-1:0] fifo_full;
  logic                 enable_change;
  logic                 any_empty;
  logic                 any_nonempty;
  logic                 aligned;
  logic                 partial;
  logic                 pop;
  logic                 skew_flush;
  logic                 flush;

  // FIFO status, push readiness and alignment decisions
  always_comb begin
    enable_change = (lane_enable != lane_enable_q);
    any_empty     = 1'b0;
    any_nonempty  = 1'b0;
    fifo_empty    = '0;
    fifo_full     = '0;
    lane_ready    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                      (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
      if (lane_enable[i]) begin
        if (fifo_empty[i]) any_empty    = 1'b1;
        else               any_nonempty = 1'b1;
      end
      // A mask change flushes everything on this edge, so refuse data rather
      // than silently dropping it; otherwise readiness is FIFO state only.
      if (enable_change)       lane_ready[i] = 1'b0;
      else if (lane_enable[i]) lane_ready[i] = !fifo_full[i];
      else                     lane_ready[i] = 1'b1;
    end
    aligned    = (|lane_enable) && !any_empty && !enable_change;
    partial    = any_nonempty && any_empty && !enable_change;
    pop        = aligned && (!out_valid_q || out_ready);
    skew_flush = partial && (skew_cnt_q == SKEW_LAST);
    flush      = skew_flush || enable_change;
  end

  // Next-state computation
  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_lane_mask_d = out_lane_mask_q;
    skew_cnt_d      = skew_cnt_q;
    skew_err_d      = skew_err_q;
    flush_count_d   = flush_count_q;
    lane_enable_d   = lane_enable;

    for (int i = 0; i < NUM_LANES; i++) begin
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end else begin
        // disabled lanes accept and discard
        if (lane_enable[i] && lane_valid[i] && lane_ready[i]) begin
          mem_d[i][wr_ptr_q[i][AW-1:0]] = lane_data[i*LANE_WIDTH +: LANE_WIDTH];
          wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
        end
        if (pop && lane_enable[i]) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        end
      end
    end

    if (pop) begin
      out_valid_d     = 1'b1;
      out_lane_mask_d = lane_enable;
      for (int i = 0; i < NUM_LANES; i++) begin
        out_data_d[i*LANE_WIDTH +: LANE_WIDTH] =
          lane_enable[i] ? mem_q[i][rd_ptr_q[i][AW-1:0]] : '0;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush || !partial) skew_cnt_d = '0;
    else                   skew_cnt_d = skew_cnt_q + CW'(1);

    // a set in the same cycle as clear_err wins
    if (skew_flush)     skew_err_d = 1'b1;
    else if (clear_err) skew_err_d = 1'b0;

    if (skew_flush && (flush_count_q != 8'hFF)) begin
      flush_count_d = flush_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      skew_cnt_q      <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_lane_mask_q <= '0;
      skew_err_q      <= 1'b0;
      flush_count_q   <= '0;
      lane_enable_q   <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      skew_cnt_q      <= skew_cnt_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_lane_mask_q <= out_lane_mask_d;
      skew_err_q      <= skew_err_d;
      flush_count_q   <= flush_count_d;
      lane_enable_q   <= lane_enable_d;
    end
  end

  // storage needs no reset: pointers define what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_lane_mask = out_lane_mask_q;
  assign skew_err      = skew_err_q;
  assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_lane_deskew_aggregator.sv
`timescale 1ns/1ps
module tb_lane_deskew_aggregator;

  localparam int NL    = 4;
  localparam int LW    = 32;
  localparam int DEPTH = 8;
  localparam int LIMIT = 16;

  logic              clk;
  logic              rst;
  logic [NL-1:0]     lane_enable;
  logic [NL-1:0]     lane_valid;
  logic [NL*LW-1:0]  lane_data;
  logic [NL-1:0]     lane_ready;
  logic              out_valid;
  logic [NL*LW-1:0]  out_data;
  logic [NL-1:0]     out_lane_mask;
  logic              out_ready;
  logic              skew_err;
  logic              clear_err;
  logic [7:0]        flush_count;

  int checks = 0;
  int errors = 0;

  lane_deskew_aggregator #(
    .NUM_LANES (NL),
    .LANE_WIDTH(LW),
    .FIFO_DEPTH(DEPTH),
    .SKEW_LIMIT(LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lane_enable  (lane_enable),
    .lane_valid   (lane_valid),
    .lane_data    (lane_data),
    .lane_ready   (lane_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_lane_mask(out_lane_mask),
    .out_ready    (out_ready),
    .skew_err     (skew_err),
    .clear_err    (clear_err),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [LW-1:0]    mq [NL][$];
  int               m_cnt;
  logic             m_valid;
  logic [NL*LW-1:0] m_data;
  logic [NL-1:0]    m_mask;
  logic             m_err;
  int               m_fc;
  logic [NL-1:0]    m_en;

  function automatic logic [NL*LW-1:0] beat(int k);
    logic [NL*LW-1:0] b;
    for (int i = 0; i < NL; i++) b[i*LW +: LW] = {8'(i), 24'(k)};
    return b;
  endfunction

  function automatic logic [NL-1:0] model_ready();
    logic [NL-1:0] r;
    for (int i = 0; i < NL; i++) begin
      if (lane_enable != m_en)  r[i] = 1'b0;
      else if (!lane_enable[i]) r[i] = 1'b1;
      else                      r[i] = (mq[i].size() < DEPTH);
    end
    return r;
  endfunction

  task automatic model_step();
    logic chg, any_e, any_ne, aligned, partial, pop, skew;
    logic [NL-1:0] rdy;
    if (rst) begin
      for (int i = 0; i < NL; i++) mq[i].delete();
      m_cnt = 0; m_valid = 1'b0; m_data = '0; m_mask = '0;
      m_err = 1'b0; m_fc = 0; m_en = '0;
    end else begin
      rdy    = model_ready();
      chg    = (lane_enable != m_en);
      any_e  = 1'b0;
      any_ne = 1'b0;
      for (int i = 0; i < NL; i++)
        if (lane_enable[i]) begin
          if (mq[i].size() == 0) any_e = 1'b1;
          else                   any_ne = 1'b1;
        end
      aligned = (lane_enable != '0) && !any_e && !chg;
      partial = any_ne && any_e && !chg;
      pop     = aligned && (!m_valid || out_ready);
      skew    = partial && (m_cnt == LIMIT - 1);
      if (pop) begin
        for (int i = 0; i < NL; i++) begin
          if (lane_enable[i]) m_data[i*LW +: LW] = mq[i].pop_front();
          else                m_data[i*LW +: LW] = '0;
        end
        m_mask  = lane_enable;
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (chg || skew) begin
        for (int i = 0; i < NL; i++) mq[i].delete();
      end else begin
        for (int i = 0; i < NL; i++)
          if (lane_enable[i] && lane_valid[i] && rdy[i]) mq[i].push_back(lane_data[i*LW +: LW]);
      end
      m_cnt = (chg || skew || !partial) ? 0 : m_cnt + 1;
      if (skew)           m_err = 1'b1;
      else if (clear_err) m_err = 1'b0;
      if (skew && m_fc < 255) m_fc++;
      m_en = lane_enable;
    end
  endtask

  // One clock: check combinational ready, advance model, check registered outputs
  task automatic tick();
    logic [NL-1:0] er;
    #1;
    er = model_ready();
    checks++;
    if (lane_ready !== er) begin
      errors++;
      $display("FAIL lane_ready t=%0t got=%b exp=%b", $time, lane_ready, er);
    end
    model_step();
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== m_valid) begin
      errors++; $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, m_valid);
    end
    checks++;
    if (out_data !== m_data) begin
      errors++; $display("FAIL out_data t=%0t got=%h exp=%h", $time, out_data, m_data);
    end
    checks++;
    if (out_lane_mask !== m_mask) begin
      errors++; $display("FAIL out_lane_mask t=%0t got=%b exp=%b", $time, out_lane_mask, m_mask);
    end
    checks++;
    if (skew_err !== m_err) begin
      errors++; $display("FAIL skew_err t=%0t got=%b exp=%b", $time, skew_err, m_err);
    end
    checks++;
    if (flush_count !== 8'(m_fc)) begin
      errors++; $display("FAIL flush_count t=%0t got=%0d exp=%0d", $time, flush_count, m_fc);
    end
  endtask

  task automatic idle(int n);
    lane_valid = '0;
    out_ready  = 1'b1;
    clear_err  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_lane(int i, logic [LW-1:0] v);
    lane_data[i*LW +: LW] = v;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; lane_enable = '0; lane_valid = '1; lane_data = '1;
    out_ready = 1'b0; clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_lane_mask !== '0) begin errors++; $display("FAIL reset_mask got=%b exp=0", out_lane_mask); end
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL reset_skew_err got=%b exp=0", skew_err); end
    checks++; if (flush_count !== 8'd0) begin errors++; $display("FAIL reset_flush_count got=%0d exp=0", flush_count); end
    rst = 1'b0; lane_valid = '0; lane_enable = 4'hF; out_ready = 1'b1;
    #1;
    checks++; if (lane_ready !== 4'h0) begin errors++; $display("FAIL reset_ready_enreg got=%b exp=0000", lane_ready); end
    tick();
    checks++; if (lane_ready !== 4'hF) begin errors++; $display("FAIL reset_ready_after got=%b exp=1111", lane_ready); end
  endtask

  // Lanes push beats 0..nb-1 as accepted; lane 3 starts at cycle 'delay'.
  task automatic run_stream(string tag, int delay, int nb, bit check_full);
    int nxt[NL];
    int got, first_out, last_out, t3;
    logic [NL-1:0] acc;
    got = 0; first_out = -1; last_out = -1; t3 = -1;
    for (int i = 0; i < NL; i++) nxt[i] = 0;
    lane_enable = 4'hF; out_ready = 1'b1; clear_err = 1'b0;
    for (int c = 0; c < 80 && got < nb; c++) begin
      for (int i = 0; i < NL; i++) begin
        lane_valid[i] = (nxt[i] < nb) && (i != 3 || c >= delay);
        set_lane(i, {8'(i), 24'(nxt[i])});
      end
      #1;
      acc = lane_valid & lane_ready;
      if (check_full && c == 8) begin
        checks++;
        if (lane_ready[2:0] !== 3'b000) begin
          errors++; $display("FAIL %s_full_ready got=%b exp=000", tag, lane_ready[2:0]);
        end
      end
      if (acc[3] && t3 < 0) t3 = c;
      tick();
      for (int i = 0; i < NL; i++) if (acc[i]) nxt[i]++;
      if (out_valid) begin
        checks++;
        if (out_data !== beat(got)) begin
          errors++; $display("FAIL %s_beat%0d got=%h exp=%h", tag, got, out_data, beat(got));
        end
        if (first_out < 0) first_out = c;
        last_out = c;
        got++;
      end
    end
    lane_valid = '0;
    checks++; if (got !== nb) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", tag, got, nb); end
    checks++; if (first_out !== t3 + 1) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", tag, first_out, t3 + 1); end
    checks++; if (last_out - first_out !== nb - 1) begin errors++; $display("FAIL %s_rate got=%0d exp=%0d", tag, last_out - first_out, nb - 1); end
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL %s_no_err got=%b exp=0", tag, skew_err); end
  endtask

  task automatic test_aligned();
    run_stream("aligned", 0, 20, 1'b0);
    idle(2);
  endtask

  task automatic test_skew_absorb();
    run_stream("skew5", 5, 12, 1'b0);
    idle(2);
    run_stream("skew10", 10, 12, 1'b1);
    idle(2);
  endtask

  task automatic test_skew_timeout();
    lane_enable = 4'hF; out_ready = 1'b1; clear_err = 1'b0;
    lane_valid = 4'b1011;
    for (int i = 0; i < NL; i++) set_lane(i, 32'h1000 + i);
    tick();
    lane_valid = '0;
    repeat (LIMIT - 1) tick();
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", skew_err); end
    tick();
    checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b exp=1", skew_err); end
    checks++; if (flush_count !== 8'd1) begin errors++; $display("FAIL timeout_fc got=%0d exp=1", flush_count); end
    // stale beats must be gone: a fresh full beat comes out alone
    lane_valid = 4'hF;
    for (int i = 0; i < NL; i++) set_lane(i, {8'(i), 24'(50)});
    tick();
    lane_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== beat(50)) begin
      errors++; $display("FAIL timeout_flushed got=%b/%h exp=1/%h", out_valid, out_data, beat(50));
    end
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL clear_err got=%b exp=0", skew_err); end
    // set wins over a simultaneous clear
    lane_valid = 4'b1011; tick(); lane_valid = '0;
    clear_err = 1'b1;
    repeat (LIMIT - 1) tick();
    tick();
    checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", skew_err); end
    checks++; if (flush_count !== 8'd2) begin errors++; $display("FAIL timeout_fc2 got=%0d exp=2", flush_count); end
    tick();
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL clear_held got=%b exp=0", skew_err); end
    clear_err = 1'b0;
    idle(2);
  endtask

  task automatic test_backpressure();
    int nxt[NL];
    int got;
    logic [NL-1:0] acc;
    for (int i = 0; i < NL; i++) nxt[i] = 0;
    lane_enable = 4'hF; out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NL; i++) begin
        lane_valid[i] = (nxt[i] < 10);
        set_lane(i, {8'(i), 24'(nxt[i])});
      end
      #1;
      acc = lane_valid & lane_ready;
      tick();
      for (int i = 0; i < NL; i++) if (acc[i]) nxt[i]++;
    end
    checks++; if (out_valid !== 1'b1 || out_data !== beat(0)) begin
      errors++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, out_data, beat(0));
    end
    checks++; if (lane_ready !== 4'h0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0000", lane_ready); end
    checks++; if (nxt[0] !== 9 || nxt[3] !== 9) begin
      errors++; $display("FAIL bp_accepted got=%0d,%0d exp=9", nxt[0], nxt[3]);
    end
    lane_valid = '0; out_ready = 1'b1; got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (out_data !== beat(got)) begin
          errors++; $display("FAIL bp_beat%0d got=%h exp=%h", got, out_data, beat(got));
        end
        got++;
      end
      tick();
    end
    checks++; if (got !== 9) begin errors++; $display("FAIL bp_count got=%0d exp=9", got); end
  endtask

  task automatic test_degraded();
    int got;
    logic [NL*LW-1:0] e;
    lane_enable = 4'b0011;
    idle(2);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      lane_valid = (c < 4) ? 4'hF : 4'h0;
      set_lane(0, {8'd0, 24'(200 + c)});
      set_lane(1, {8'd1, 24'(200 + c)});
      set_lane(2, 32'hDEADBEEF);
      set_lane(3, 32'hDEADBEEF);
      #1;
      if (c < 4) begin
        checks++;
        if (lane_ready[3:2] !== 2'b11) begin errors++; $display("FAIL deg_ready got=%b exp=11", lane_ready[3:2]); end
      end
      tick();
      if (out_valid) begin
        e = beat(200 + got);
        e[NL*LW-1:64] = '0;
        checks++;
        if (out_data !== e || out_lane_mask !== 4'b0011) begin
          errors++; $display("FAIL deg_beat%0d got=%h/%b exp=%h/0011", got, out_data, out_lane_mask, e);
        end
        got++;
      end
    end
    checks++; if (got !== 4) begin errors++; $display("FAIL deg_count got=%0d exp=4", got); end
  endtask

  task automatic test_enable_change();
    int got;
    lane_enable = 4'hF;
    idle(3);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      lane_valid = 4'hF;
      for (int i = 0; i < NL; i++) set_lane(i, {8'(i), 24'(100 + c)});
      tick();
    end
    lane_valid = '0;
    lane_enable = 4'h3;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== beat(100)) begin
      errors++; $display("FAIL en_out_held got=%b/%h exp=1/%h", out_valid, out_data, beat(100));
    end
    checks++; if (skew_err !== 1'b0 || flush_count !== 8'd2) begin
      errors++; $display("FAIL en_no_err got=%b/%0d exp=0/2", skew_err, flush_count);
    end
    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) got++;
      tick();
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL en_flushed got=%0d exp=1", got); end
    lane_enable = 4'hF;
    idle(2);
  endtask

  task automatic test_random();
    int dut_beats, mdl_beats;
    logic [NL-1:0] en;
    dut_beats = 0; mdl_beats = 0; en = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63) == 0) en = NL'($urandom_range(15));
      lane_enable = en;
      for (int i = 0; i < NL; i++) begin
        lane_valid[i] = ($urandom_range(9) < 8);
        set_lane(i, $urandom());
      end
      out_ready = ($urandom_range(3) != 0);
      clear_err = ($urandom_range(31) == 0);
      rst       = ($urandom_range(999) == 0);
      if (out_valid && out_ready) dut_beats++;
      if (m_valid && out_ready)   mdl_beats++;
      tick();
    end
    rst = 1'b0; clear_err = 1'b0;
    checks++; if (dut_beats !== mdl_beats) begin
      errors++; $display("FAIL rand_beats got=%0d exp=%0d", dut_beats, mdl_beats);
    end
  endtask

  task automatic test_saturation();
    lane_enable = 4'hF;
    idle(LIMIT + 4);
    for (int n = 0; n < 260; n++) begin
      lane_valid = 4'b0001;
      set_lane(0, 32'(n));
      tick();
      lane_valid = '0;
      repeat (LIMIT) tick();
    end
    checks++; if (flush_count !== 8'd255) begin errors++; $display("FAIL sat_fc got=%0d exp=255", flush_count); end
    checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL sat_err got=%b exp=1", skew_err); end
  endtask

  task automatic test_reset_midstream();
    lane_enable = 4'hF; out_ready = 1'b0;
    lane_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NL; i++) set_lane(i, {8'(i), 24'(300 + c)});
      tick();
    end
    #1;
    checks++; if (lane_ready !== 4'h0) begin errors++; $display("FAIL mid_full got=%b exp=0000", lane_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0; lane_valid = '0;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_lane_mask !== '0) begin
      errors++; $display("FAIL mid_rst_out got=%b/%h/%b exp=0/0/0", out_valid, out_data, out_lane_mask);
    end
    checks++; if (skew_err !== 1'b0 || flush_count !== 8'd0) begin
      errors++; $display("FAIL mid_rst_err got=%b/%0d exp=0/0", skew_err, flush_count);
    end
    checks++; if (lane_ready !== 4'h0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0000", lane_ready); end
    tick();
    checks++; if (lane_ready !== 4'hF) begin errors++; $display("FAIL mid_ready_after got=%b exp=1111", lane_ready); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned();
    test_skew_absorb();
    test_skew_timeout();
    test_backpressure();
    test_degraded();
    test_enable_change();
    test_random();
    test_saturation();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
